// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares one single-port frame-buffer RAM between VGA scan-out,
//            a built-in clear-screen sequencer and one pixel writer.
//            Display reads have hard priority. The clear sequencer and the
//            writer use every other cycle. The buffer is upscaled by
//            2^SCALE_LOG2 in both axes.
// Ports    : i_Clk, i_Rst_L       pixel clock, async active-low reset
//            i_valid, i_x, i_y    timing-generator active flag and coordinates
//            o_pixel, o_pix_valid pixel and valid, both 2 cycles after i_x/i_y
//            i_wr_*, o_wr_ready   writer valid/ready handshake
//            i_clear, i_clear_color, o_busy   clear-screen control
//            o_ram_*, i_ram_rdata RAM port with a 1-cycle synchronous read
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2,    // must be >= 1
  parameter int DATA_W     = 9,
  parameter int ADDR_W     = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_valid,
  input  logic [11:0]       i_x,
  input  logic [11:0]       i_y,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_pix_valid,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_clear_color,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int              FB_WORDS   = FB_W * FB_H;
  localparam int              ADDR_W1    = ADDR_W + 1;
  localparam logic [ADDR_W:0] C_FB_WORDS = ADDR_W1'(FB_WORDS);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0] C_FB_W   = ADDR_W'(FB_W);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   clr_color_q, clr_color_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                vld1_q, vld1_d;
  logic                vld2_q, vld2_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic                disp_slot;
  logic                free_slot;
  logic                clr_go;
  logic                wr_ready;
  logic                wr_go;
  logic [ADDR_W-1:0]   disp_addr;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;

  // Row-times-width as a sum of shifted partial products of the constant
  // FB_W, so it maps onto plain adders rather than a hard multiplier.
  function automatic logic [ADDR_W-1:0] mul_fb_w(input logic [ADDR_W-1:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (C_FB_W[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

  always_comb begin
    // Slot decode is gated by reset so nothing reaches the RAM while held.
    disp_slot = i_Rst_L & i_valid & (i_x[SCALE_LOG2-1:0] == '0);
    free_slot = i_Rst_L & ~disp_slot;
    clr_go    = free_slot & (state_q == ST_CLEAR);
    wr_ready  = free_slot & (state_q == ST_IDLE);
    // Out-of-range writes still handshake but never reach the RAM.
    wr_go     = wr_ready & i_wr_valid & ({1'b0, i_wr_addr} < C_FB_WORDS);
    disp_addr = mul_fb_w(ADDR_W'(i_y >> SCALE_LOG2)) + ADDR_W'(i_x >> SCALE_LOG2);

    ram_addr  = last_addr_q;
    ram_wdata = '0;
    if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (clr_go) begin
      ram_addr  = clr_addr_q;
      ram_wdata = clr_color_q;
    end else if (wr_go) begin
      ram_addr  = i_wr_addr;
      ram_wdata = i_wr_data;
    end
    last_addr_d = ram_addr;

    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = i_clear_color;
        end
      end
      ST_CLEAR: begin
        // i_clear is ignored here: a running fill is never restarted.
        if (clr_go) begin
          if (clr_addr_q == C_LAST) state_d = ST_IDLE;
          else                      clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read issued at t, data on the RAM bus at t+1, shown from t+2.
    rd_pend_d = disp_slot;
    hold_d    = rd_pend_q ? i_ram_rdata : hold_q;
    vld1_d    = i_valid;
    vld2_d    = vld1_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      last_addr_q <= '0;
      rd_pend_q   <= 1'b0;
      hold_q      <= '0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      last_addr_q <= last_addr_d;
      rd_pend_q   <= rd_pend_d;
      hold_q      <= hold_d;
      vld1_q      <= vld1_d;
      vld2_q      <= vld2_d;
    end
  end

  assign o_pixel     = vld2_q ? hold_q : '0;
  assign o_pix_valid = vld2_q;
  assign o_wr_ready  = wr_ready;
  assign o_busy      = (state_q == ST_CLEAR);
  assign o_ram_addr  = ram_addr;
  assign o_ram_we    = clr_go | wr_go;
  assign o_ram_wdata = ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Self-checking bench for vga_fb_arbiter with a behavioural
//            1-cycle-latency RAM, a directed vector table and hand-written
//            clear-screen and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic        i_valid;
  logic [11:0] i_x, i_y;
  logic [8:0]  o_pixel;
  logic        o_pix_valid;
  logic        i_wr_valid;
  logic [14:0] i_wr_addr;
  logic [8:0]  i_wr_data;
  logic        o_wr_ready;
  logic        i_clear;
  logic [8:0]  i_clear_color;
  logic        o_busy;
  logic [14:0] o_ram_addr;
  logic        o_ram_we;
  logic [8:0]  o_ram_wdata;
  logic [8:0]  i_ram_rdata;

  logic [8:0]  mem [0:32767];

  int n_vec = 0;
  int n_bad = 0;
  int scan_k = 0;

  always #5 i_Clk = ~i_Clk;

  vga_fb_arbiter dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_valid(i_valid), .i_x(i_x), .i_y(i_y),
    .o_pixel(o_pixel), .o_pix_valid(o_pix_valid),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready), .i_clear(i_clear), .i_clear_color(i_clear_color),
    .o_busy(o_busy), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always @(posedge i_Clk) begin
    if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    i_ram_rdata <= mem[o_ram_addr];
  end

  typedef struct {
    logic        v;
    logic [11:0] x, y;
    logic        wv;
    logic [14:0] wa;
    logic [8:0]  wd;
    logic        e_rdy, e_we;
    logic [14:0] e_addr;
    logic [8:0]  e_wdata;
    logic        e_pv;
    logic [8:0]  e_pix;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(input bit v, input int x, input int y,
                              input bit wv, input int wa, input int wd,
                              input bit rdy, input bit we, input int addr, input int wdata,
                              input bit pv, input int pix);
    vec_t r;
    r.v = v; r.x = 12'(x); r.y = 12'(y);
    r.wv = wv; r.wa = 15'(wa); r.wd = 9'(wd);
    r.e_rdy = rdy; r.e_we = we; r.e_addr = 15'(addr); r.e_wdata = 9'(wdata);
    r.e_pv = pv; r.e_pix = 9'(pix);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scan pattern: 20 active pixels then 8 blanking cycles per line, 32 lines.
  task automatic drive_scan(input int k);
    i_valid = ((k % 28) < 20);
    i_x     = 12'(k % 28);
    i_y     = 12'((k / 28) % 32);
  endtask

  function automatic bit is_disp(input int k);
    return ((k % 28) < 20) && ((k % 28) % 4 == 0);
  endfunction

  function automatic logic [14:0] exp_addr(input int k);
    return 15'((((k / 28) % 32) / 4) * 160 + (k % 28) / 4);
  endfunction

  // Runs the scan with the writer permanently requesting while a clear is in
  // progress, until 'target' in-order clear writes have been seen.
  task automatic run_clear(input int target, input logic [8:0] color, input bit poke);
    int cnt = 0, bad_disp = 0, bad_clr = 0, bad_rdy = 0, bad_busy = 0, cyc = 0;
    while (cnt < target && cyc < 40000) begin
      @(negedge i_Clk);
      drive_scan(scan_k);
      i_wr_valid    = 1'b1;
      i_wr_addr     = 15'd7;
      i_wr_data     = 9'h1FF;
      i_clear       = poke && (cyc == 100);
      i_clear_color = 9'h1C0;
      #1;
      if (o_busy !== 1'b1) bad_busy++;
      if (o_wr_ready !== 1'b0) bad_rdy++;
      if (is_disp(scan_k)) begin
        if (o_ram_we !== 1'b0 || o_ram_addr !== exp_addr(scan_k)) bad_disp++;
      end else if (o_ram_we === 1'b1 && o_ram_addr === 15'(cnt) && o_ram_wdata === color) begin
        cnt++;
      end else begin
        bad_clr++;
      end
      scan_k++;
      cyc++;
    end
    i_clear = 1'b0;
    chk("clear_count", cnt, target);
    chk("clear_display_slots", bad_disp, 0);
    chk("clear_sequence", bad_clr, 0);
    chk("clear_wr_ready", bad_rdy, 0);
    chk("clear_busy", bad_busy, 0);
  endtask

  initial begin
    vt[0]  = mk(0, 0, 0,  0, 0, 0,          1, 0, 163, 0,          0, 0);
    vt[1]  = mk(1, 4, 4,  0, 0, 0,          0, 0, 161, 0,          0, 0);
    vt[2]  = mk(1, 5, 4,  0, 0, 0,          1, 0, 161, 0,          0, 0);
    vt[3]  = mk(1, 6, 4,  0, 0, 0,          1, 0, 161, 0,          1, 'h1C0);
    vt[4]  = mk(1, 7, 4,  0, 0, 0,          1, 0, 161, 0,          1, 'h1C0);
    vt[5]  = mk(1, 8, 4,  0, 0, 0,          0, 0, 162, 0,          1, 'h1C0);
    vt[6]  = mk(1, 9, 4,  1, 5, 'h0AA,      1, 1, 5, 'h0AA,        1, 'h1C0);
    vt[7]  = mk(1, 10, 4, 0, 0, 0,          1, 0, 5, 0,            1, 'h03F);
    vt[8]  = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            1, 'h03F);
    vt[9]  = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            1, 'h03F);
    vt[10] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            0, 0);
    vt[11] = mk(1, 12, 4, 1, 5, 'h0AA,      0, 0, 163, 0,          0, 0);
    vt[12] = mk(1, 13, 4, 1, 5, 'h0AA,      1, 1, 5, 'h0AA,        0, 0);
    vt[13] = mk(1, 14, 4, 0, 0, 0,          1, 0, 5, 0,            1, 'h155);
    vt[14] = mk(0, 0, 0,  1, 19200, 'h1FF,  1, 0, 5, 0,            1, 'h155);
    vt[15] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            1, 'h155);
    vt[16] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            0, 0);
    vt[17] = mk(1, 20, 0, 0, 0, 0,          0, 0, 5, 0,            0, 0);
    vt[18] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            0, 0);
    vt[19] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            1, 'h0AA);
    vt[20] = mk(0, 0, 0,  0, 0, 0,          1, 0, 5, 0,            0, 0);
    vt[21] = mk(0, 0, 0,  1, 19199, 'h0F0,  1, 1, 19199, 'h0F0,    0, 0);

    i_Rst_L = 1'b0; i_valid = 1'b0; i_x = '0; i_y = '0;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_clear = 1'b0; i_clear_color = '0;
    repeat (3) @(negedge i_Clk);
    i_Rst_L = 1'b1;
    #1;
    chk("rst.pixel",     o_pixel, 0);
    chk("rst.pix_valid", o_pix_valid, 0);
    chk("rst.we",        o_ram_we, 0);
    chk("rst.addr",      o_ram_addr, 0);
    chk("rst.ready",     o_wr_ready, 1);
    chk("rst.busy",      o_busy, 0);

    // Preload the words the display table reads, through the writer port.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clk);
      i_wr_valid = 1'b1;
      i_wr_addr  = 15'(161 + i);
      i_wr_data  = (i == 0) ? 9'h1C0 : (i == 1) ? 9'h03F : 9'h155;
      #1;
      chk($sformatf("preload%0d.ready", i), o_wr_ready, 1);
      chk($sformatf("preload%0d.we", i),    o_ram_we, 1);
    end

    for (int i = 0; i < 22; i++) begin
      @(negedge i_Clk);
      i_valid = vt[i].v; i_x = vt[i].x; i_y = vt[i].y;
      i_wr_valid = vt[i].wv; i_wr_addr = vt[i].wa; i_wr_data = vt[i].wd;
      #1;
      chk($sformatf("v%0d.ready", i), o_wr_ready, vt[i].e_rdy);
      chk($sformatf("v%0d.we", i),    o_ram_we,   vt[i].e_we);
      chk($sformatf("v%0d.addr", i),  o_ram_addr, vt[i].e_addr);
      if (vt[i].e_we) chk($sformatf("v%0d.wdata", i), o_ram_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d.pix_valid", i), o_pix_valid, vt[i].e_pv);
      chk($sformatf("v%0d.pixel", i),     o_pixel,     vt[i].e_pix);
    end

    // Full clear, with a second i_clear mid-way that must be ignored.
    @(negedge i_Clk);
    i_valid = 1'b0; i_wr_valid = 1'b0; i_clear = 1'b1; i_clear_color = 9'h007;
    #1;
    chk("clear_start.busy", o_busy, 0);
    run_clear(19200, 9'h007, 1'b1);
    @(negedge i_Clk);
    i_valid = 1'b0; i_wr_valid = 1'b0;
    #1;
    chk("clear_done.busy",  o_busy, 0);
    chk("clear_done.ready", o_wr_ready, 1);
    @(negedge i_Clk);
    chk("clear.mem0",     mem[0], 9'h007);
    chk("clear.mem7",     mem[7], 9'h007);
    chk("clear.mem19199", mem[19199], 9'h007);

    // Reset in the middle of a clear, then a fresh clear from address 0.
    @(negedge i_Clk);
    i_clear = 1'b1; i_clear_color = 9'h1F8;
    run_clear(5000, 9'h1F8, 1'b0);
    @(negedge i_Clk);
    i_Rst_L = 1'b0;
    #1;
    chk("midrst.busy",      o_busy, 0);
    chk("midrst.we",        o_ram_we, 0);
    chk("midrst.pixel",     o_pixel, 0);
    chk("midrst.pix_valid", o_pix_valid, 0);
    chk("midrst.ready",     o_wr_ready, 0);
    @(negedge i_Clk);
    i_valid = 1'b0; i_wr_valid = 1'b0;
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    #1;
    chk("post_rst.busy", o_busy, 0);
    @(negedge i_Clk);
    i_clear = 1'b1; i_clear_color = 9'h038;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_Clk);
      i_clear = 1'b0;
      #1;
      chk($sformatf("restart%0d.we", i),    o_ram_we, 1);
      chk($sformatf("restart%0d.addr", i),  o_ram_addr, i);
      chk($sformatf("restart%0d.wdata", i), o_ram_wdata, 9'h038);
    end
    @(negedge i_Clk);
    chk("restart.mem2",    mem[2], 9'h038);
    chk("partial.mem4000", mem[4000], 9'h1F8);
    chk("partial.mem6000", mem[6000], 9'h007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
